// File: rtl/sr_latch_bank_arbiter_if.sv
// ============================================================================
//  Module   : sr_latch_bank_arbiter_if
//  Brief    : Requester and latch-bank signal bundle for the SR latch arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface sr_latch_bank_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int NLATCH = 8,
    parameter int IDXW   = 3
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      op;
    logic [NREQ*IDXW-1:0] idx;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [NLATCH-1:0]    latch_s;
    logic [NLATCH-1:0]    latch_r;
    logic                 latch_en;
    logic [NLATCH-1:0]    latch_q;

    // Environment side: requesters plus the latch bank Q outputs.
    modport master (
        output req, op, idx, latch_q,
        input  gnt, done, err, latch_s, latch_r, latch_en
    );

    modport slave (
        input  req, op, idx, latch_q,
        output gnt, done, err, latch_s, latch_r, latch_en
    );
endinterface

`default_nettype wire

// File: rtl/sr_latch_bank_arbiter.sv
// ============================================================================
//  Module   : sr_latch_bank_arbiter
//  Brief    : Round-robin arbiter sequencing set/clear writes into a gated SR latch bank.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sr_latch_bank_arbiter #(
    parameter int NREQ         = 4,
    parameter int NLATCH       = 8,
    parameter int IDXW         = 3,
    parameter int PULSE_CYCLES = 3
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    sr_latch_bank_arbiter_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [GW-1:0]     r_ptr;
    logic [GW-1:0]     r_g;
    logic              r_op;
    logic [IDXW-1:0]   r_idx;
    logic              r_oor;
    logic              r_q;
    logic [CW-1:0]     r_cnt;

    logic              w_found;
    logic [GW-1:0]     w_pick;
    logic              w_pick_op;
    logic [IDXW-1:0]   w_pick_idx;
    logic              w_pick_oor;
    logic [NLATCH-1:0] w_sel;
    logic [NREQ-1:0]   w_g1h;
    logic              w_sr_active;

    // Scan starting at the pointer so the last-served requester ranks lowest.
    always_comb begin : p_arb
        logic [GW-1:0] w_k;
        w_k        = '0;
        w_found    = 1'b0;
        w_pick     = '0;
        w_pick_op  = 1'b0;
        w_pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_k = GW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && bus.req[w_k]) begin
                w_found    = 1'b1;
                w_pick     = w_k;
                w_pick_op  = bus.op[w_k];
                w_pick_idx = bus.idx[int'(w_k)*IDXW +: IDXW];
            end
        end
        w_pick_oor = (int'(w_pick_idx) >= NLATCH);
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NLATCH; i++) begin
            w_sel[i] = (r_idx == IDXW'(i)) && !r_oor;
        end
        w_g1h = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_g1h[i] = (r_g == GW'(i));
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = w_pick_oor ? S_DONE : S_SETUP;
            S_SETUP: w_next = S_PULSE;
            S_PULSE: if (r_cnt == '0) w_next = S_HOLD;
            S_HOLD:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_g     <= '0;
            r_op    <= 1'b0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_q     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_g   <= w_pick;
                        r_op  <= w_pick_op;
                        r_idx <= w_pick_idx;
                        r_oor <= w_pick_oor;
                    end
                end
                S_SETUP: r_cnt <= CW'(PULSE_CYCLES - 1);
                S_PULSE: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                S_HOLD:  r_q   <= |(bus.latch_q & w_sel);
                S_DONE:  r_ptr <= GW'((int'(r_g) + 1) % NREQ);
                default: ;
            endcase
        end
    end

    // S/R are held across SETUP..HOLD so the enable edge never coincides with an S/R change.
    assign w_sr_active  = (r_state == S_SETUP) || (r_state == S_PULSE) || (r_state == S_HOLD);
    assign bus.latch_s  = (w_sr_active &&  r_op) ? w_sel : '0;
    assign bus.latch_r  = (w_sr_active && !r_op) ? w_sel : '0;
    assign bus.latch_en = (r_state == S_PULSE);
    assign bus.gnt      = (r_state != S_IDLE) ? w_g1h : '0;
    assign bus.done     = (r_state == S_DONE) ? w_g1h : '0;
    assign bus.err      = (r_state == S_DONE) && (r_oor || (r_q != r_op));

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_bank_arbiter.sv
// ============================================================================
//  Module   : tb_sr_latch_bank_arbiter
//  Brief    : Scoreboard bench for the SR latch bank arbiter with a latch-bank model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sr_latch_bank_arbiter;
    localparam int NREQ = 4;
    localparam int IDXW = 3;

    typedef struct {
        int   id;
        logic err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t e;

    logic [7:0] bank_q = 8'h00;
    logic [7:0] stuck0 = 8'h00;
    logic       prev_en = 1'b0;
    logic [7:0] prev_s  = 8'h00;
    logic [7:0] prev_r  = 8'h00;

    always #5 clk = ~clk;

    sr_latch_bank_arbiter_if #(.NREQ(NREQ), .NLATCH(8), .IDXW(IDXW)) bus ();
    sr_latch_bank_arbiter_if #(.NREQ(NREQ), .NLATCH(6), .IDXW(IDXW)) bus6 ();

    sr_latch_bank_arbiter #(.NREQ(NREQ), .NLATCH(8), .IDXW(IDXW), .PULSE_CYCLES(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    sr_latch_bank_arbiter #(.NREQ(NREQ), .NLATCH(6), .IDXW(IDXW), .PULSE_CYCLES(3)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6)
    );

    // Gated SR latch bank: transparent while enable is high, bits optionally stuck at 0.
    always @(negedge clk) begin
        if (bus.latch_en) bank_q <= (bank_q & ~bus.latch_r) | bus.latch_s;
    end
    assign bus.latch_q  = bank_q & ~stuck0;
    assign bus6.latch_q = 6'h00;

    // Invariant monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n) begin
            n_total++;
            if (((bus.latch_s & bus.latch_r) != 0) || ($countones(bus.latch_s | bus.latch_r) > 1) ||
                ($countones(bus.gnt) > 1) || (bus.err && bus.done == 0) ||
                (bus.latch_en && !prev_en && (bus.latch_s != prev_s || bus.latch_r != prev_r)))
                $display("FAIL invariant: s=%h r=%h en=%b gnt=%b done=%b err=%b prev_en=%b prev_s=%h prev_r=%h",
                         bus.latch_s, bus.latch_r, bus.latch_en, bus.gnt, bus.done, bus.err, prev_en, prev_s, prev_r);
            else n_pass++;
            if (bus.done != 0) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_done: got done=%b err=%b, expected no done", bus.done, bus.err);
                end else begin
                    e = sb.pop_front();
                    if (bus.done !== (4'b0001 << e.id) || bus.err !== e.err)
                        $display("FAIL sb_done: got done=%b err=%b, expected done=%b err=%b",
                                 bus.done, bus.err, 4'b0001 << e.id, e.err);
                    else n_pass++;
                end
            end
        end
        prev_en <= bus.latch_en;
        prev_s  <= bus.latch_s;
        prev_r  <= bus.latch_r;
    end

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.op   = 4'b1111;
        bus.idx  = 12'h000;
        bus6.req = 4'b0000;
        bus6.op  = 4'b0000;
        bus6.idx = 12'h000;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.gnt, bus.done, bus.err, bus.latch_s, bus.latch_r, bus.latch_en} !== 30'd0)
            $display("FAIL reset_outputs: got gnt=%b done=%b err=%b s=%h r=%h en=%b, expected all 0",
                     bus.gnt, bus.done, bus.err, bus.latch_s, bus.latch_r, bus.latch_en);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b, expected 0001", bus.gnt);
        else n_pass++;
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_set();
        int s_cnt = 0, en_cnt = 0, done_cyc = -1;
        bus.req = 4'b0100;
        bus.op  = 4'b0100;
        bus.idx = 12'h000;
        bus.idx[2*IDXW +: IDXW] = 3'd5;
        sb.push_back('{id: 2, err: 1'b0});
        for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (bus.latch_s === 8'h20 && bus.latch_r === 8'h00) s_cnt++;
            if (bus.latch_en) en_cnt++;
            if (bus.done[2]) begin
                done_cyc = c;
                bus.req  = 4'b0000;
            end
        end
        n_total++;
        if (done_cyc !== 6) $display("FAIL single_latency: got done cycle %0d, expected 6", done_cyc);
        else n_pass++;
        n_total++;
        if (s_cnt !== 5) $display("FAIL single_s_cycles: got %0d, expected 5", s_cnt);
        else n_pass++;
        n_total++;
        if (en_cnt !== 3) $display("FAIL single_en_cycles: got %0d, expected 3", en_cnt);
        else n_pass++;
        n_total++;
        if (bus.latch_q[5] !== 1'b1) $display("FAIL single_q5: got %b, expected 1", bus.latch_q[5]);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.gnt !== 4'b0000) $display("FAIL single_idle_after: got gnt=%b, expected 0000", bus.gnt);
        else n_pass++;
    endtask

    task automatic test_contention();
        int order[5];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        logic was_done = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        bus.op  = 4'b0101;
        bus.idx = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 5; k++) sb.push_back('{id: exp_order[k], err: 1'b0});
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            if (was_done) begin
                n_total++;
                if (bus.gnt !== 4'b0000) $display("FAIL contention_idle_gap: got gnt=%b, expected 0000", bus.gnt);
                else n_pass++;
            end
            was_done = (bus.done != 0);
            if (bus.done != 0) begin
                for (int b = 0; b < NREQ; b++) if (bus.done[b]) order[n] = b;
                n++;
                if (n == 5) bus.req = 4'b0000;
            end
        end
        n_total++;
        if (n !== 5) $display("FAIL contention_count: got %0d dones, expected 5", n);
        else n_pass++;
        for (int k = 0; k < n; k++) begin
            n_total++;
            if (order[k] !== exp_order[k])
                $display("FAIL contention_order[%0d]: got %0d, expected %0d", k, order[k], exp_order[k]);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ((bus.latch_q & 8'h0F) !== 8'h05)
            $display("FAIL contention_bank: got q[3:0]=%h, expected 5", bus.latch_q & 8'h0F);
        else n_pass++;
    endtask

    task automatic test_readback_fail();
        logic got_err;
        int   done_cyc;
        stuck0 = 8'h08;
        for (int pass = 0; pass < 2; pass++) begin
            bus.req = 4'b0010;
            bus.op  = (pass == 0) ? 4'b0010 : 4'b0000;
            bus.idx = 12'h000;
            bus.idx[1*IDXW +: IDXW] = 3'd3;
            sb.push_back('{id: 1, err: (pass == 0)});
            done_cyc = -1;
            got_err  = 1'b0;
            for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
                @(negedge clk);
                if (bus.done[1]) begin
                    done_cyc = c;
                    got_err  = bus.err;
                    bus.req  = 4'b0000;
                end
            end
            n_total++;
            if (done_cyc < 0 || got_err !== (pass == 0))
                $display("FAIL readback_err[%0d]: got done cycle %0d err=%b, expected done with err=%b",
                         pass, done_cyc, got_err, (pass == 0));
            else n_pass++;
            @(negedge clk);
        end
        stuck0 = 8'h00;
    endtask

    task automatic test_out_of_range();
        logic en_seen = 1'b0, sr_seen = 1'b0, got_err = 1'b0;
        int   done_cyc = -1;
        bus6.req = 4'b0001;
        bus6.op  = 4'b0001;
        bus6.idx = 12'h000;
        bus6.idx[0 +: IDXW] = 3'd7;
        for (int c = 1; c <= 8 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (bus6.latch_en) en_seen = 1'b1;
            if ((bus6.latch_s | bus6.latch_r) != 0) sr_seen = 1'b1;
            if (bus6.done != 0) begin
                n_total++;
                if (bus6.done !== 4'b0001) $display("FAIL oor_done: got %b, expected 0001", bus6.done);
                else n_pass++;
                done_cyc = c;
                got_err  = bus6.err;
                bus6.req = 4'b0000;
            end
        end
        n_total++;
        if (done_cyc !== 1 || got_err !== 1'b1)
            $display("FAIL oor_err: got done cycle %0d err=%b, expected cycle 1 err=1", done_cyc, got_err);
        else n_pass++;
        n_total++;
        if (en_seen || sr_seen)
            $display("FAIL oor_quiet: got en_seen=%b sr_seen=%b, expected 0 0", en_seen, sr_seen);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_midop();
        int done_cyc = -1;
        int t = 0;
        // Requester drops req during the enable pulse.
        bus.req = 4'b1000;
        bus.op  = 4'b1000;
        bus.idx = 12'h000;
        bus.idx[3*IDXW +: IDXW] = 3'd6;
        sb.push_back('{id: 3, err: 1'b0});
        while (!bus.latch_en && t < 6) begin @(negedge clk); t++; end
        bus.req = 4'b0000;
        for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (bus.done[3]) done_cyc = c;
        end
        n_total++;
        if (done_cyc < 0 || bus.latch_q[6] !== 1'b1)
            $display("FAIL midop_drop: got done cycle %0d q6=%b, expected done and q6=1", done_cyc, bus.latch_q[6]);
        else n_pass++;
        @(negedge clk);
        // Reset lands in the middle of the enable pulse.
        bus.req = 4'b0001;
        bus.op  = 4'b0001;
        bus.idx = 12'h000;
        bus.idx[0 +: IDXW] = 3'd1;
        t = 0;
        while (!bus.latch_en && t < 6) begin @(negedge clk); t++; end
        bus.req = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.latch_en !== 1'b0 || bus.gnt !== 4'b0000 || t >= 6)
            $display("FAIL midop_reset: got en=%b gnt=%b wait=%0d, expected en=0 gnt=0000", bus.latch_en, bus.gnt, t);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.gnt !== 4'b0000) $display("FAIL midop_idle: got gnt=%b, expected 0000", bus.gnt);
        else n_pass++;
        bus.req = 4'b0010;
        bus.op  = 4'b0010;
        bus.idx = 12'h000;
        bus.idx[1*IDXW +: IDXW] = 3'd4;
        sb.push_back('{id: 1, err: 1'b0});
        done_cyc = -1;
        for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (bus.done[1]) begin
                done_cyc = c;
                bus.req  = 4'b0000;
            end
        end
        n_total++;
        if (done_cyc !== 6) $display("FAIL midop_recover: got done cycle %0d, expected 6", done_cyc);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_contention();
        test_readback_fail();
        test_out_of_range();
        test_midop();
        repeat (2) @(negedge clk);
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
